// File: rtl/mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_if -- bundle between the multi-cycle controller and its datapath.
//
//   master : the controller (mc_ctrl). Receives the fetched instruction,
//            fetch/memory handshakes and ALU flags. Drives the datapath
//            control fields and one-cycle strobes.
//   slave  : the datapath / memory side (or a testbench standing in for it).
//
// Signals
//   instr[31:0]    fetched instruction word, valid when instr_valid=1
//   instr_valid    fetch handshake complete
//   mem_ready      data-memory access complete
//   less, zero     ALU flags (zero=1: operands equal)
//   fetch_req      request next instruction
//   ALUctr[3:0]    ALU operation
//   ALUAsrc        0 rs1, 1 pc
//   ALUBsrc[1:0]   00 rs2, 01 imm, 10 constant 4
//   ExtOp[2:0]     immediate format 000 I, 001 U, 010 S, 011 B, 100 J
//   RegWr, MemRd, MemWr, PCWr   one-cycle strobes
//   MemOP[2:0]     funct3 of the load/store in flight
//   PCsrc[1:0]     00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//   halted         illegal instruction seen
// ---------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic        less;
    logic        zero;
    logic        fetch_req;
    logic [3:0]  ALUctr;
    logic        ALUAsrc;
    logic [1:0]  ALUBsrc;
    logic [2:0]  ExtOp;
    logic        RegWr;
    logic        MemRd;
    logic        MemWr;
    logic        PCWr;
    logic [2:0]  MemOP;
    logic [1:0]  PCsrc;
    logic        halted;

    modport master (
        input  instr, instr_valid, mem_ready, less, zero,
        output fetch_req, ALUctr, ALUAsrc, ALUBsrc, ExtOp,
               RegWr, MemRd, MemWr, PCWr, MemOP, PCsrc, halted
    );

    modport slave (
        output instr, instr_valid, mem_ready, less, zero,
        input  fetch_req, ALUctr, ALUAsrc, ALUBsrc, ExtOp,
               RegWr, MemRd, MemWr, PCWr, MemOP, PCsrc, halted
    );
endinterface

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle RV32I control unit.
//
// Sequence: FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH, with HALT as a
// sticky sink for illegal encodings (left only through reset).
//
// Ports
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous, active-high reset
//   bus   mc_ctrl_if.master (instruction, handshakes, flags in; controls out)
//
// Control fields and most strobes are registered: they are computed on the
// transition into the state that uses them. Three outputs cannot be known one
// cycle early and are resolved combinationally in the state itself:
//   - PCsrc of a branch in EXEC depends on the ALU flags of that cycle,
//   - PCWr of a store fires in the MEM cycle that sees mem_ready,
//   - every strobe is forced low while rst is high, so a reset arriving in
//     MEM or WB never lets a write or PC update escape.
// ---------------------------------------------------------------------------
module mc_ctrl (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    state_t      state_reg;
    logic [31:0] ir_reg;
    logic        halted_reg;
    logic [3:0]  alu_ctr_reg;
    logic        alu_asrc_reg;
    logic [1:0]  alu_bsrc_reg;
    logic [2:0]  ext_op_reg;
    logic [2:0]  memop_reg;
    logic [1:0]  pcsrc_reg;
    logic        fetch_req_reg;
    logic        regwr_reg;
    logic        memrd_reg;
    logic        memwr_reg;
    logic        pcwr_reg;

    // ------------------------------------------------------------------
    // IR field decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_branch;
    logic       is_load;
    logic       is_store;

    assign opcode    = ir_reg[6:0];
    assign funct3    = ir_reg[14:12];
    assign funct7    = ir_reg[31:25];
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);

    // Register specifiers and immediate bits belong to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_reg[24:15], ir_reg[11:7]};

    // ALU code for register/immediate arithmetic: {alt, funct3}, except that
    // sltu lives at 1010 rather than 0011 (0011 is pass-B for LUI).
    function automatic logic [3:0] arith_ctr(input logic [2:0] f3, input logic alt);
        if (f3 == 3'b011) begin
            return 4'b1010;
        end
        return {alt, f3};
    endfunction

    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:   legal = (funct3 == 3'b000);
            OPC_BRANCH: legal = (funct3[2:1] != 2'b01);
            OPC_LOAD:   legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            OPC_STORE:  legal = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            OPC_OPIMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == 7'h00);
                    3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: legal = (funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            default: legal = 1'b0;
        endcase
    end

    logic [3:0] alu_ctr_d;
    logic       alu_asrc_d;
    logic [1:0] alu_bsrc_d;
    logic [2:0] ext_op_d;
    logic [1:0] pcsrc_d;
    always_comb begin
        alu_ctr_d  = 4'b0000;
        alu_asrc_d = 1'b0;
        alu_bsrc_d = 2'b01;
        ext_op_d   = EXT_I;
        pcsrc_d    = 2'b00;
        case (opcode)
            OPC_OP: begin
                alu_bsrc_d = 2'b00;
                alu_ctr_d  = arith_ctr(funct3, funct7[5] &&
                                       ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            // funct7[5] of an immediate op only means "arithmetic" on srai;
            // elsewhere it is just an immediate bit, so addi never becomes sub.
            OPC_OPIMM: alu_ctr_d = arith_ctr(funct3, funct7[5] && (funct3 == 3'b101));
            OPC_LUI: begin
                alu_ctr_d = 4'b0011;
                ext_op_d  = EXT_U;
            end
            OPC_AUIPC: begin
                alu_asrc_d = 1'b1;
                ext_op_d   = EXT_U;
            end
            // Jumps compute the link value pc+4; the target comes from PCsrc.
            OPC_JAL: begin
                alu_asrc_d = 1'b1;
                alu_bsrc_d = 2'b10;
                ext_op_d   = EXT_J;
                pcsrc_d    = 2'b01;
            end
            OPC_JALR: begin
                alu_asrc_d = 1'b1;
                alu_bsrc_d = 2'b10;
                pcsrc_d    = 2'b10;
            end
            OPC_BRANCH: begin
                alu_ctr_d  = funct3[1] ? 4'b1010 : 4'b0010;
                alu_bsrc_d = 2'b00;
                ext_op_d   = EXT_B;
            end
            OPC_STORE: ext_op_d = EXT_S;
            default: ;
        endcase
    end

    logic taken;
    always_comb begin
        case (funct3)
            3'b000:         taken = bus.zero;
            3'b001:         taken = !bus.zero;
            3'b100, 3'b110: taken = bus.less;
            default:        taken = !bus.less;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            ir_reg        <= IR_NOP;
            halted_reg    <= 1'b0;
            alu_ctr_reg   <= 4'b0000;
            alu_asrc_reg  <= 1'b0;
            alu_bsrc_reg  <= 2'b00;
            ext_op_reg    <= EXT_I;
            memop_reg     <= 3'b000;
            pcsrc_reg     <= 2'b00;
            fetch_req_reg <= 1'b0;
            regwr_reg     <= 1'b0;
            memrd_reg     <= 1'b0;
            memwr_reg     <= 1'b0;
            pcwr_reg      <= 1'b0;
        end else begin
            fetch_req_reg <= 1'b0;
            regwr_reg     <= 1'b0;
            pcwr_reg      <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        ir_reg    <= bus.instr;
                        state_reg <= S_DECODE;
                    end else begin
                        fetch_req_reg <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg    <= S_EXEC;
                        alu_ctr_reg  <= alu_ctr_d;
                        alu_asrc_reg <= alu_asrc_d;
                        alu_bsrc_reg <= alu_bsrc_d;
                        ext_op_reg   <= ext_op_d;
                        pcsrc_reg    <= pcsrc_d;
                        memop_reg    <= (is_load || is_store) ? funct3 : 3'b000;
                        // A branch retires in EXEC, so its PC update is armed now.
                        pcwr_reg     <= is_branch;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        state_reg     <= S_FETCH;
                        fetch_req_reg <= 1'b1;
                    end else if (is_load || is_store) begin
                        state_reg <= S_MEM;
                        memrd_reg <= is_load;
                        memwr_reg <= is_store;
                    end else begin
                        state_reg <= S_WB;
                        regwr_reg <= 1'b1;
                        pcwr_reg  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        memrd_reg <= 1'b0;
                        memwr_reg <= 1'b0;
                        if (is_load) begin
                            state_reg <= S_WB;
                            regwr_reg <= 1'b1;
                            pcwr_reg  <= 1'b1;
                        end else begin
                            state_reg     <= S_FETCH;
                            fetch_req_reg <= 1'b1;
                            memop_reg     <= 3'b000;
                        end
                    end
                end
                S_WB: begin
                    state_reg     <= S_FETCH;
                    fetch_req_reg <= 1'b1;
                    pcsrc_reg     <= 2'b00;
                    memop_reg     <= 3'b000;
                end
                S_HALT: ;
                default: state_reg <= S_HALT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic store_done;
    assign store_done = (state_reg == S_MEM) && is_store && bus.mem_ready;

    // Strobe order: fetch_req, RegWr, MemRd, MemWr, PCWr
    logic [4:0] strobe_raw;
    logic [4:0] strobe_out;
    assign strobe_raw = {fetch_req_reg, regwr_reg, memrd_reg, memwr_reg, pcwr_reg | store_done};

    for (genvar gi = 0; gi < 5; gi++) begin : g_strobe_gate
        assign strobe_out[gi] = strobe_raw[gi] & ~rst;
    end

    assign bus.fetch_req = strobe_out[4];
    assign bus.RegWr     = strobe_out[3];
    assign bus.MemRd     = strobe_out[2];
    assign bus.MemWr     = strobe_out[1];
    assign bus.PCWr      = strobe_out[0];

    assign bus.ALUctr  = alu_ctr_reg;
    assign bus.ALUAsrc = alu_asrc_reg;
    assign bus.ALUBsrc = alu_bsrc_reg;
    assign bus.ExtOp   = ext_op_reg;
    assign bus.MemOP   = memop_reg;
    assign bus.halted  = halted_reg;
    assign bus.PCsrc   = ((state_reg == S_EXEC) && is_branch) ? {1'b0, taken} : pcsrc_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Directed cases first, then randomly built instruction words (legal and
// illegal) checked cycle by cycle against a mnemonic-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    typedef enum int {
        M_ILL, M_LUI, M_AUIPC, M_JAL, M_JALR,
        M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND
    } mnem_t;

    localparam logic [1:0] K_WB = 2'd0, K_BR = 2'd1, K_LD = 2'd2, K_ST = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [1:0] kind;
        logic [3:0] aluctr;
        logic       asrc;
        logic [1:0] bsrc;
        logic [2:0] extop;
        logic       ext_chk;
        logic [1:0] pcsrc;
        logic [2:0] memop;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {fetch_req, RegWr, MemRd, MemWr, PCWr}
    task automatic chk_strobes(input string tag, input logic [4:0] exp);
        chk(tag, 32'({bus.fetch_req, bus.RegWr, bus.MemRd, bus.MemWr, bus.PCWr}), 32'(exp));
    endtask

    // ---------------- reference model ----------------
    function automatic mnem_t mnem(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        case (op)
            7'h37: return M_LUI;
            7'h17: return M_AUIPC;
            7'h6F: return M_JAL;
            7'h67: return (f3 == 3'd0) ? M_JALR : M_ILL;
            7'h63: case (f3)
                3'd0: return M_BEQ;   3'd1: return M_BNE;
                3'd4: return M_BLT;   3'd5: return M_BGE;
                3'd6: return M_BLTU;  3'd7: return M_BGEU;
                default: return M_ILL;
            endcase
            7'h03: case (f3)
                3'd0: return M_LB;  3'd1: return M_LH;  3'd2: return M_LW;
                3'd4: return M_LBU; 3'd5: return M_LHU;
                default: return M_ILL;
            endcase
            7'h23: case (f3)
                3'd0: return M_SB; 3'd1: return M_SH; 3'd2: return M_SW;
                default: return M_ILL;
            endcase
            7'h13: case (f3)
                3'd0: return M_ADDI;  3'd2: return M_SLTI;  3'd3: return M_SLTIU;
                3'd4: return M_XORI;  3'd6: return M_ORI;   3'd7: return M_ANDI;
                3'd1: return (f7 == 7'h00) ? M_SLLI : M_ILL;
                default: return (f7 == 7'h00) ? M_SRLI : ((f7 == 7'h20) ? M_SRAI : M_ILL);
            endcase
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: return M_ADD; 3'd1: return M_SLL; 3'd2: return M_SLT;
                        3'd3: return M_SLTU; 3'd4: return M_XOR; 3'd5: return M_SRL;
                        3'd6: return M_OR;  default: return M_AND;
                    endcase
                end
                if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
                return M_ILL;
            end
            default: return M_ILL;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic less, input logic zero);
        exp_t  e;
        mnem_t m;
        logic  tk;
        m = mnem(i);
        e = '0;
        e.legal = (m != M_ILL);
        e.kind = K_WB;
        e.bsrc = 2'b01;
        e.ext_chk = 1'b1;
        tk = 1'b0;
        case (m)
            M_SUB:                               e.aluctr = 4'b1000;
            M_SLL, M_SLLI:                       e.aluctr = 4'b0001;
            M_SLT, M_SLTI, M_BEQ, M_BNE, M_BLT, M_BGE: e.aluctr = 4'b0010;
            M_SLTU, M_SLTIU, M_BLTU, M_BGEU:     e.aluctr = 4'b1010;
            M_XOR, M_XORI:                       e.aluctr = 4'b0100;
            M_SRL, M_SRLI:                       e.aluctr = 4'b0101;
            M_SRA, M_SRAI:                       e.aluctr = 4'b1101;
            M_OR, M_ORI:                         e.aluctr = 4'b0110;
            M_AND, M_ANDI:                       e.aluctr = 4'b0111;
            M_LUI:                               e.aluctr = 4'b0011;
            default:                             e.aluctr = 4'b0000;
        endcase
        case (m)
            M_BEQ:         tk = zero;
            M_BNE:         tk = !zero;
            M_BLT, M_BLTU: tk = less;
            M_BGE, M_BGEU: tk = !less;
            default:       tk = 1'b0;
        endcase
        case (m)
            M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND: begin
                e.bsrc = 2'b00;
                e.ext_chk = 1'b0;
            end
            M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin
                e.kind = K_BR; e.bsrc = 2'b00; e.extop = 3'b011; e.pcsrc = {1'b0, tk};
            end
            M_LUI:   e.extop = 3'b001;
            M_AUIPC: begin e.asrc = 1'b1; e.extop = 3'b001; end
            M_JAL:   begin e.asrc = 1'b1; e.bsrc = 2'b10; e.extop = 3'b100; e.pcsrc = 2'b01; end
            M_JALR:  begin e.asrc = 1'b1; e.bsrc = 2'b10; e.pcsrc = 2'b10; end
            M_LB, M_LH, M_LW, M_LBU, M_LHU: begin e.kind = K_LD; e.memop = i[14:12]; end
            M_SB, M_SH, M_SW: begin e.kind = K_ST; e.extop = 3'b010; e.memop = i[14:12]; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  f7;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h63;
            5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
            default: op = 7'($urandom());
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2, 3: f7 = 7'h00;
            4, 5, 6, 7: f7 = 7'h20;
            default:    f7 = 7'($urandom());
        endcase
        return {f7, r[24:7], op};
    endfunction

    // ---------------- transaction tasks ----------------
    // Entry/exit point of every task: just after a negedge check that found
    // the controller in FETCH with fetch_req=1.
    task automatic do_reset();
        $display("reset");
        @(negedge clk);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("rst_no_write", 32'({bus.RegWr, bus.MemWr, bus.PCWr}), 32'(3'b000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_strobes("rst_strobes", 5'b00000);
        chk("rst_halted", 32'(bus.halted), 32'(0));
        chk("rst_aluctr", 32'(bus.ALUctr), 32'(0));
        chk("rst_asrc", 32'(bus.ALUAsrc), 32'(0));
        chk("rst_bsrc", 32'(bus.ALUBsrc), 32'(0));
        chk("rst_extop", 32'(bus.ExtOp), 32'(0));
        chk("rst_pcsrc", 32'(bus.PCsrc), 32'(0));
        chk("rst_memop", 32'(bus.MemOP), 32'(0));
        @(negedge clk);
        #1;
        chk_strobes("rst_fetch", 5'b10000);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic lv, input logic zv,
                             input int mem_wait, input bit rst_in_mem);
        exp_t e;
        logic ld;
        logic st;
        e = model(ins, lv, zv);
        ld = (e.kind == K_LD);
        st = (e.kind == K_ST);
        $display("instr %08h legal=%0d kind=%0d less=%0d zero=%0d wait=%0d rst_mem=%0d",
                 ins, e.legal, e.kind, lv, zv, mem_wait, rst_in_mem);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = $urandom();
        #1;
        chk_strobes("decode_strobes", 5'b00000);
        chk("decode_halted", 32'(bus.halted), 32'(0));
        @(negedge clk);
        bus.less = lv;
        bus.zero = zv;
        #1;
        if (!e.legal) begin
            chk("halt_flag", 32'(bus.halted), 32'(1));
            chk_strobes("halt_strobes", 5'b00000);
            for (int k = 0; k < 3; k++) begin
                bus.instr_valid = 1'b1;
                bus.instr = 32'h0000_0013;
                @(negedge clk);
                #1;
                chk("halt_sticky", 32'(bus.halted), 32'(1));
                chk_strobes("halt_ignore", 5'b00000);
            end
            bus.instr_valid = 1'b0;
            do_reset();
            return;
        end
        chk("exec_aluctr", 32'(bus.ALUctr), 32'(e.aluctr));
        chk("exec_asrc", 32'(bus.ALUAsrc), 32'(e.asrc));
        chk("exec_bsrc", 32'(bus.ALUBsrc), 32'(e.bsrc));
        if (e.ext_chk) chk("exec_extop", 32'(bus.ExtOp), 32'(e.extop));
        if (e.kind == K_BR) begin
            chk_strobes("br_exec_strobes", 5'b00001);
            chk("br_pcsrc", 32'(bus.PCsrc), 32'(e.pcsrc));
        end else begin
            chk_strobes("exec_strobes", 5'b00000);
        end
        if (ld || st) begin
            for (int w = 0; w <= mem_wait; w++) begin
                if (rst_in_mem && w == 1) begin
                    do_reset();
                    return;
                end
                @(negedge clk);
                bus.mem_ready = (w == mem_wait);
                #1;
                chk_strobes("mem_strobes", {3'b001 & {1'b0, 1'b0, ld}, st, st && (w == mem_wait)});
                chk("mem_memop", 32'(bus.MemOP), 32'(e.memop));
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            if (ld) begin
                chk_strobes("ld_wb_strobes", 5'b01001);
                chk("ld_wb_pcsrc", 32'(bus.PCsrc), 32'(0));
                @(negedge clk);
                #1;
            end
        end else if (e.kind == K_WB) begin
            @(negedge clk);
            #1;
            chk_strobes("wb_strobes", 5'b01001);
            chk("wb_pcsrc", 32'(bus.PCsrc), 32'(e.pcsrc));
            @(negedge clk);
            #1;
        end else begin
            @(negedge clk);
            #1;
        end
        chk_strobes("back_fetch", 5'b10000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr = 32'h0;
        bus.instr_valid = 1'b0;
        bus.mem_ready = 1'b0;
        bus.less = 1'b0;
        bus.zero = 1'b0;
        do_reset();
        run_instr(32'h002081B3, 1'b0, 1'b0, 0, 1'b0);  // add x3,x1,x2
        run_instr(32'h00208463, 1'b0, 1'b1, 0, 1'b0);  // beq taken
        run_instr(32'h00208463, 1'b0, 1'b0, 0, 1'b0);  // beq not taken
        run_instr(32'h0020E463, 1'b1, 1'b0, 0, 1'b0);  // bltu taken
        run_instr(32'h0000A283, 1'b0, 1'b0, 3, 1'b0);  // lw, 3 wait cycles
        run_instr(32'h0050A223, 1'b0, 1'b0, 0, 1'b0);  // sw, immediate ready
        run_instr(32'h4020D1B3, 1'b0, 1'b0, 0, 1'b0);  // sra
        run_instr(32'h4000D093, 1'b0, 1'b0, 0, 1'b0);  // srai
        run_instr(32'h008000EF, 1'b0, 1'b0, 0, 1'b0);  // jal
        run_instr(32'h000080E7, 1'b0, 1'b0, 0, 1'b0);  // jalr
        run_instr(32'h0000007F, 1'b0, 1'b0, 0, 1'b0);  // illegal opcode -> HALT
        run_instr(32'h0020A463, 1'b0, 1'b0, 0, 1'b0);  // branch funct3 010 -> HALT
        run_instr(32'h0000A283, 1'b0, 1'b0, 3, 1'b1);  // lw aborted by reset in MEM
        for (int n = 0; n < 80; n++) begin
            run_instr(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
